// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demultiplexer: each accepted word is steered by
// in_sel into one of two independent 2-entry lane FIFOs with delivery counters.

module stream_demux_lane #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop_rdy,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);
  logic [1:0][WIDTH-1:0] r_mem;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;
  logic [WIDTH-1:0]      r_last;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_pop;

  assign o_valid = (r_occ != 2'd0);
  assign o_full  = (r_occ == 2'd2);
  assign w_pop   = o_valid && i_pop_rdy;
  // An empty lane keeps showing the word it last delivered.
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      r_last   <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= ~r_rd_ptr;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
      unique case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end
endmodule

module stream_demux_1to2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            w_sel_oh;
  logic [NUM_LANES-1:0]            w_push;
  logic [NUM_LANES-1:0]            w_full;
  logic [NUM_LANES-1:0]            w_valid;
  logic [NUM_LANES-1:0]            w_pop_rdy;
  logic [NUM_LANES-1:0][WIDTH-1:0] w_data;
  logic [NUM_LANES-1:0][CNT_W-1:0] w_cnt;
  logic                            w_accept;

  // Ready depends only on the selected lane's registered fullness, never on
  // the downstream ready inputs, so a freed slot is usable one cycle later.
  assign w_sel_oh  = {in_sel, ~in_sel};
  assign in_ready  = ~w_full[in_sel];
  assign w_accept  = in_valid && in_ready;
  assign w_push    = {NUM_LANES{w_accept}} & w_sel_oh;
  assign w_pop_rdy = {out1_ready, out0_ready};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    stream_demux_lane #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (w_push[g]),
      .i_data    (in_data),
      .i_pop_rdy (w_pop_rdy[g]),
      .o_full    (w_full[g]),
      .o_valid   (w_valid[g]),
      .o_data    (w_data[g]),
      .o_cnt     (w_cnt[g])
    );
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_data[0];
  assign out1_data  = w_data[1];
  assign cnt0       = w_cnt[0];
  assign cnt1       = w_cnt[1];
endmodule

// File: tb/tb_stream_demux_1to2.sv
// Scoreboard bench for stream_demux_1to2: per-lane expected-word queues fed on
// accepted input, popped and compared by a negedge monitor on delivery.

module tb_stream_demux_1to2;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sel = 1'b0;
  logic             out0_valid, out1_valid;
  logic             out0_ready = 1'b0, out1_ready = 1'b0;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;

  int total = 0;
  int bad = 0;

  logic [WIDTH-1:0] mq [2][$];
  logic [WIDTH-1:0] mlast [2];
  int               mcnt [2];
  logic             last_fire = 1'b0;

  stream_demux_1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: lane contents as plain queues, counters as integers.
  always @(negedge clk) begin
    logic             ov [2];
    logic             ordy [2];
    logic [WIDTH-1:0] od [2];
    logic [CNT_W-1:0] oc [2];
    logic             exp_v;
    logic             exp_rdy;
    ov = '{out0_valid, out1_valid};
    ordy = '{out0_ready, out1_ready};
    od = '{out0_data, out1_data};
    oc = '{cnt0, cnt1};
    if (!rst_n) begin
      for (int l = 0; l < 2; l++) begin
        mq[l].delete();
        mlast[l] = '0;
        mcnt[l] = 0;
        chk($sformatf("rst_valid%0d", l), int'(ov[l]), 0);
        chk($sformatf("rst_cnt%0d", l), int'(oc[l]), 0);
        chk($sformatf("rst_data%0d", l), int'(od[l]), 0);
      end
      last_fire = 1'b0;
    end else begin
      exp_rdy = (mq[in_sel].size() < 2);
      chk("in_ready", int'(in_ready), int'(exp_rdy));
      for (int l = 0; l < 2; l++) begin
        exp_v = (mq[l].size() != 0);
        chk($sformatf("valid%0d", l), int'(ov[l]), int'(exp_v));
        chk($sformatf("data%0d", l), int'(od[l]), exp_v ? int'(mq[l][0]) : int'(mlast[l]));
        chk($sformatf("cnt%0d", l), int'(oc[l]), mcnt[l] % (1 << CNT_W));
        if (exp_v && ordy[l]) begin
          mlast[l] = mq[l].pop_front();
          mcnt[l]++;
        end
      end
      last_fire = in_valid && exp_rdy;
      if (last_fire) mq[in_sel].push_back(in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic s, output int cyc);
    in_valid = 1'b1;
    in_data = d;
    in_sel = s;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (in_ready) break;
      if (cyc >= 200) begin
        chk("send_timeout", cyc, 0);
        break;
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    while ((out0_valid || out1_valid) && n < 100) begin
      step();
      n++;
    end
    chk("drain_timeout", int'(out0_valid || out1_valid), 0);
  endtask

  initial begin
    int c;
    int sum;
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset mid-cycle with two words held in lane 0.
    send(8'hD1, 1'b0, c);
    send(8'hD2, 1'b0, c);
    chk("pre_rst_valid0", int'(out0_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid0", int'(out0_valid), 0);
    chk("arst_valid1", int'(out1_valid), 0);
    chk("arst_cnt0", int'(cnt0), 0);
    chk("arst_data0", int'(out0_data), 0);
    out0_ready = 1'b1;
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // Counter wrap with a 4-bit counter.
    for (int i = 0; i < 15; i++) send(8'(i + 1), 1'b0, c);
    drain();
    chk("wrap_cnt15", int'(cnt0), 15);
    send(8'h40, 1'b0, c);
    drain();
    chk("wrap_cnt0", int'(cnt0), 0);
    send(8'h41, 1'b0, c);
    drain();
    chk("wrap_cnt1", int'(cnt0), 1);

    // Routing and one-cycle latency.
    send(8'hA5, 1'b0, c);
    chk("route_v0", int'(out0_valid), 1);
    chk("route_d0", int'(out0_data), 8'hA5);
    chk("route_v1_quiet", int'(out1_valid), 0);
    send(8'h3C, 1'b1, c);
    chk("route_v1", int'(out1_valid), 1);
    chk("route_d1", int'(out1_data), 8'h3C);
    chk("route_v0_done", int'(out0_valid), 0);
    step();
    chk("route_cnt0", int'(cnt0), 2);
    chk("route_cnt1", int'(cnt1), 1);

    // Full lane and backpressure.
    out0_ready = 1'b0;
    send(8'h11, 1'b0, c);
    send(8'h22, 1'b0, c);
    in_valid = 1'b1; in_data = 8'h33; in_sel = 1'b0;
    @(negedge clk); chk("full_block", int'(in_ready), 0);
    step(); out0_ready = 1'b1;
    @(negedge clk); chk("full_pop_cycle", int'(in_ready), 0);
    step();
    @(negedge clk); chk("full_after_pop", int'(in_ready), 1);
    step(); in_valid = 1'b0;
    drain();
    chk("full_cnt0", int'(cnt0), 5);

    // Head-of-line blocking.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    send(8'h44, 1'b0, c);
    send(8'h55, 1'b0, c);
    send(8'h77, 1'b1, c);
    chk("hol_other_lane", c, 1);
    out1_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h88; in_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("hol_stall", int'(in_ready), 0);
      step();
    end
    chk("hol_lane1_gone", int'(out1_valid), 0);
    out0_ready = 1'b1;
    send(8'h88, 1'b0, c);
    drain();

    // Simultaneous push and pop: no bubbles.
    out1_ready = 1'b0;
    send(8'h99, 1'b1, c);
    out1_ready = 1'b1;
    sum = 0;
    for (int i = 1; i <= 16; i++) begin
      send(8'(i), 1'b1, c);
      sum += c;
    end
    chk("stream_cycles", sum, 16);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int bias = (i / 500) % 3;
      if (!(in_valid && !last_fire)) begin
        in_valid = ($urandom % 4) != 0;
        in_data = 8'($urandom);
        in_sel = 1'($urandom);
      end
      out0_ready = ($urandom % 4) >= 1 + bias;
      out1_ready = ($urandom % 3) != 0;
      step();
    end
    in_valid = 1'b0;
    drain();
    step();
    chk("final_q0_empty", mq[0].size(), 0);
    chk("final_q1_empty", mq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Registered 1-to-2 stream demultiplexer; it is the inverse of the team's 2-to-1 mux.
- Routes each accepted input word to output lane 0 or lane 1 according to a per-word select bit, using valid/ready handshakes on all three ports.
- Each lane has a 2-entry FIFO so both lanes can stream at full rate independently.
- Sits between a single producer (e.g. test-vector sequencer or datapath) and two consumers.

Parameters:
WIDTH, 8, data width of input and both output lanes
CNT_W, 16, width of per-lane delivered-word counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer has a word
in_ready  output  1  block accepts word this cycle
in_data  input  WIDTH  input word
in_sel  input  1  destination lane (0 -> out0, 1 -> out1), qualified by in_valid
out0_valid  output  1  lane 0 head word valid
out0_ready  input  1  lane 0 consumer accepts
out0_data  output  WIDTH  lane 0 head word
out1_valid  output  1  lane 1 head word valid
out1_ready  input  1  lane 1 consumer accepts
out1_data  output  WIDTH  lane 1 head word
cnt0  output  CNT_W  words delivered on lane 0
cnt1  output  CNT_W  words delivered on lane 1

Behaviour:
- Reset: asynchronous, takes effect immediately when rst_n goes low, regardless of clk.
  - Both FIFOs emptied; all pointers and occupancies set to 0.
  - out0_valid = out1_valid = 0; out0_data = out1_data = 0; cnt0 = cnt1 = 0.
  - Reset mid-transfer discards all buffered words; no output handshake completes while rst_n is low.
- Handshake transfer occurs when valid && ready are both high at a rising clk edge.
  - Producer holds in_data/in_sel stable while in_valid is high and in_ready is low.
- in_ready = (occupancy of lane in_sel) < 2.
  - Combinational only from in_sel and registered occupancy.
  - No combinational path from out0_ready/out1_ready to in_ready.
- Push: word written into FIFO of lane in_sel. Never written to the other lane.
- Latency: a word accepted at edge N gives outX_valid = 1 with that word on outX_data after edge N, when the lane was empty. There is no same-cycle bypass.
- outX_valid = (occupancy X != 0). outX_data = head entry of lane X.
  - When lane X is empty, outX_data holds the last popped value (0 after reset).
- Pop: when outX_valid && outX_ready, the head entry is removed and cntX increments by 1.
  - cntX wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Push and pop on the same lane in the same cycle: occupancy unchanged; the new word goes behind the current entries.
- Full lane (occupancy 2): in_ready is low for that in_sel, so the push is blocked. A pop in that cycle frees a slot; the push becomes possible the next cycle.
- Head-of-line blocking: if the selected lane is full, input stalls even when the other lane is empty. No reordering or skipping.
- Ordering:
  - Strict FIFO order within each lane.
  - No ordering relation between lanes.
- Both lanes may pop in the same cycle, and one lane may pop while the other is pushed.
- outX_ready while empty: no effect; the counter does not change.
- Occupancy per lane is 0..2. Pointers are 1 bit each and wrap 1 -> 0.

Test Plan:
- Reset: drive rst_n low mid-cycle with lane 0 holding 2 words -> out0_valid and out1_valid are 0 immediately; cnt0 = cnt1 = 0; out0_data = 0.
- Routing and latency: push 0xA5 with sel = 0, then 0x3C with sel = 1; out0_ready = out1_ready = 1 -> out0 shows 0xA5 one cycle after acceptance and out1 shows 0x3C one cycle after its acceptance; cnt0 = 1, cnt1 = 1; 0xA5 never appears on out1.
- Full and backpressure: out0_ready = 0; push 0x11, 0x22, 0x33 to lane 0 ->
  - in_ready drops after 2 accepts.
  - Raising out0_ready delivers 0x11, 0x22, 0x33 in order, and 0x33 is accepted the cycle after the first pop.
  - cnt0 = 3.
- Head-of-line: lane 0 full with out0_ready = 0; present 0x77 with sel = 1 -> accepted (in_ready = 1). Then present 0x88 with sel = 0 -> stalled; lane 1 still delivers 0x77.
- Simultaneous push and pop: lane 1 holds 1 word with out1_ready = 1; stream 0x01..0x10 continuously -> one word per cycle, no bubbles, occupancy stays at 1, cnt1 advances by 16 relative to its start.
- Counter wrap (CNT_W = 4 override): deliver 17 words on lane 0 -> cnt0 reads 15, then 0, then 1.
